uart_cmd_seq: RTL and testbench

- ASCII command sequencer between the UART byte engine and the Wishbone host fabric.
- Parses line-based commands from the host UART: `wm <addr> <data>` for a register write and `rm <addr>` for a register read.
- Issues one Wishbone transaction per command, then returns an ASCII response through the UART transmit byte port.
- Sits inside the wishbone host, between the UART core and the Wishbone master bus. It is the sole sequencer of the bridge.

---
 rtl/uart_cmd_seq.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_cmd_seq.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_cmd_seq
// Purpose : ASCII command sequencer between the UART byte engine and the
//           Wishbone master. Parses "wm <adr> <dat>" / "rm <adr>" lines,
//           runs one bus transaction per line and returns an ASCII reply.
// Revision: 1.0 - initial release
// ============================================================================
module uart_cmd_seq #(
  parameter int         WB_TMO  = 255,
  parameter logic [3:0] SEL_DEF = 4'hF
) (
  input  logic        app_clk,
  input  logic        reset_n,
  input  logic        cfg_en,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_req,
  input  logic        tx_ack,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        rx_ovr,
  output logic        busy
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_CW   = 4'd1;
  localparam logic [3:0] S_CR   = 4'd2;
  localparam logic [3:0] S_SP1  = 4'd3;
  localparam logic [3:0] S_ADDR = 4'd4;
  localparam logic [3:0] S_AEND = 4'd5;
  localparam logic [3:0] S_DATA = 4'd6;
  localparam logic [3:0] S_DEND = 4'd7;
  localparam logic [3:0] S_SKIP = 4'd8;
  localparam logic [3:0] S_WB   = 4'd9;
  localparam logic [3:0] S_RESP = 4'd10;

  localparam logic [2:0] C_OKW = 3'd0;
  localparam logic [2:0] C_OKR = 3'd1;
  localparam logic [2:0] C_ERR = 3'd2;
  localparam logic [2:0] C_BE  = 3'd3;
  localparam logic [2:0] C_TMO = 3'd4;

  localparam logic [7:0]  CH_CR    = 8'h0D;
  localparam logic [7:0]  CH_LF    = 8'h0A;
  localparam logic [7:0]  CH_SP    = 8'h20;
  localparam logic [15:0] TMO_LAST = 16'(WB_TMO - 1);

  logic [3:0]  state;
  logic        is_wr;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [2:0]  cnt;
  logic [2:0]  code;
  logic [31:0] rdat;
  logic [3:0]  idx;
  logic [15:0] tmo_cnt;
  logic        eat_lf;
  logic        is_hex;
  logic [3:0]  nib;
  logic        is_eol;
  logic        parse_st;
  logic [3:0]  bad_st;
  logic [3:0]  last_idx;
  logic [7:0]  byte_cur;
  logic [7:0]  byte_nxt;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Byte i of the reply selected by the completion code.
  function automatic logic [7:0] resp_byte(input logic [2:0] c, input logic [31:0] d,
                                           input logic [3:0] i);
    logic [31:0] sh;
    logic [7:0]  c0;
    logic [7:0]  c1;
    sh = d << {i[2:0], 2'b00};
    case (c)
      C_OKW:   begin c0 = 8'h6F; c1 = 8'h6B; end  // "ok"
      C_BE:    begin c0 = 8'h62; c1 = 8'h65; end  // "be"
      C_TMO:   begin c0 = 8'h74; c1 = 8'h6F; end  // "to"
      default: begin c0 = 8'h65; c1 = 8'h72; end  // "er"
    endcase
    if (c == C_OKR)
      resp_byte = (i == 4'd8) ? CH_LF : hex_char(sh[31:28]);
    else if (i == 4'd0)
      resp_byte = c0;
    else if (i == 4'd1)
      resp_byte = c1;
    else
      resp_byte = CH_LF;
  endfunction

  // Classify the incoming byte: hex digit value, line terminator, error exit.
  always_comb begin
    is_hex = 1'b0;
    nib    = rx_data[3:0];
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_hex = 1'b1;
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0] + 4'd9;
    end
    is_eol   = (rx_data == CH_CR) || (rx_data == CH_LF);
    // A malformed line ending on its terminator replies at once; otherwise
    // the rest of the line is swallowed first.
    bad_st   = is_eol ? S_RESP : S_SKIP;
    parse_st = (state != S_WB) && (state != S_RESP);
    last_idx = (code == C_OKR) ? 4'd8 : 4'd2;
    byte_cur = resp_byte(code, rdat, idx);
    byte_nxt = resp_byte(code, rdat, idx + 4'd1);
  end

  // Parser, bus sequencer and reply shifter.
  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      is_wr     <= 1'b0;
      adr       <= 32'h0;
      dat       <= 32'h0;
      cnt       <= 3'd0;
      code      <= C_ERR;
      rdat      <= 32'h0;
      idx       <= 4'd0;
      tmo_cnt   <= 16'd0;
      eat_lf    <= 1'b0;
      rx_ovr    <= 1'b0;
      tx_req    <= 1'b0;
      tx_data   <= 8'h0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
    end else begin
      // The LF of a CR/LF pair that terminated a command is not an overrun.
      if (rx_valid)
        eat_lf <= cfg_en && parse_st && (rx_data == CH_CR);
      if (!cfg_en)
        rx_ovr <= 1'b0;
      else if (rx_valid && !parse_st && !(eat_lf && rx_data == CH_LF))
        rx_ovr <= 1'b1;

      case (state)
        S_WB: begin
          if (!wbm_cyc_o) begin
            if (!cfg_en) begin
              state <= S_IDLE;
            end else begin
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_we_o  <= is_wr;
              tmo_cnt   <= 16'd0;
            end
          end else if (wbm_err_i || wbm_ack_i || tmo_cnt == TMO_LAST) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            idx       <= 4'd0;
            state     <= cfg_en ? S_RESP : S_IDLE;
            if (wbm_err_i) begin
              code <= C_BE;
            end else if (wbm_ack_i) begin
              code <= is_wr ? C_OKW : C_OKR;
              rdat <= wbm_dat_i;
            end else begin
              code <= C_TMO;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        S_RESP: begin
          if (!tx_req) begin
            if (!cfg_en) begin
              state <= S_IDLE;
            end else begin
              tx_req  <= 1'b1;
              tx_data <= byte_cur;
            end
          end else if (tx_ack) begin
            if (!cfg_en || idx == last_idx) begin
              tx_req <= 1'b0;
              state  <= S_IDLE;
            end else begin
              idx     <= idx + 4'd1;
              tx_data <= byte_nxt;
            end
          end
        end

        default: begin
          if (!cfg_en) begin
            state <= S_IDLE;
          end else if (rx_valid) begin
            code <= C_ERR;
            idx  <= 4'd0;
            case (state)
              S_IDLE: begin
                if (rx_data == 8'h77) begin
                  is_wr <= 1'b1;
                  state <= S_CW;
                end else if (rx_data == 8'h72) begin
                  is_wr <= 1'b0;
                  state <= S_CR;
                end else if (!is_eol) begin
                  state <= S_SKIP;
                end
              end
              S_CW, S_CR: state <= (rx_data == 8'h6D) ? S_SP1 : bad_st;
              S_SP1: begin
                cnt   <= 3'd0;
                state <= (rx_data == CH_SP) ? S_ADDR : bad_st;
              end
              S_ADDR: begin
                if (is_hex) begin
                  adr <= {adr[27:0], nib};
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'd7) state <= S_AEND;
                end else begin
                  state <= bad_st;
                end
              end
              S_AEND: begin
                if (is_wr && rx_data == CH_SP) begin
                  cnt   <= 3'd0;
                  state <= S_DATA;
                end else if (!is_wr && is_eol) begin
                  state <= S_WB;
                end else begin
                  state <= bad_st;
                end
              end
              S_DATA: begin
                if (is_hex) begin
                  dat <= {dat[27:0], nib};
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'd7) state <= S_DEND;
                end else begin
                  state <= bad_st;
                end
              end
              S_DEND:  state <= is_eol ? S_WB : S_SKIP;
              S_SKIP:  if (is_eol) state <= S_RESP;
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign wbm_adr_o = adr;
  assign wbm_dat_o = dat;
  assign wbm_sel_o = SEL_DEF;
  assign busy      = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_uart_cmd_seq
// Purpose : Scoreboard bench for uart_cmd_seq: a line-level reference model
//           predicts bus transactions and replies; UART and Wishbone
//           monitors pop and compare.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_cmd_seq;

  localparam int TMO = 16;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_en = 1'b1;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        tx_ack = 1'b0;
  logic [31:0] wbm_dat_i = 32'h0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_req;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        rx_ovr, busy;

  int          errors = 0;
  int          checks = 0;
  int          bus_mode = 0;  // 0 ack, 1 bus error, 2 never respond
  wb_t         exp_wb[$];
  string       exp_resp[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];
  string       s_cr, s_lf, s_crlf;

  uart_cmd_seq #(.WB_TMO(TMO), .SEL_DEF(4'hF)) dut (
    .app_clk(clk), .reset_n(reset_n), .cfg_en(cfg_en),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_req(tx_req), .tx_ack(tx_ack),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .rx_ovr(rx_ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic string esc(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0a)                      r = {r, "\\n"};
      else if (s[i] == 8'h0d)                 r = {r, "\\r"};
      else if (s[i] < 8'h20 || s[i] > 8'h7e)  r = $sformatf("%s<%02h>", r, s[i]);
      else                                    r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  function automatic string hex8(input logic [31:0] v, input bit upper);
    string s = "";
    logic [3:0] n;
    for (int i = 7; i >= 0; i--) begin
      n = v[i*4 +: 4];
      s = $sformatf("%s%c", s, (n < 4'd10) ? (8'h30 + {4'h0, n})
                                            : ((upper ? 8'h37 : 8'h57) + {4'h0, n}));
    end
    return s;
  endfunction

  function automatic bit hexval(input logic [7:0] c, output logic [3:0] v);
    v = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) begin v = c[3:0]; return 1'b1; end
    if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      v = c[3:0] + 4'd9;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Line-level reference: a command is valid only if it matches the exact
  // text grammar; every other non-empty line answers "er".
  function automatic void model(input string line, output string resp,
                                output bit wb, output wb_t t);
    bit ok;
    logic [3:0]  v;
    logic [31:0] a, d, rd;
    wb = 0; t = '0; a = 0; d = 0; resp = "er\n"; ok = 0;
    if (line.len() == 20 && line.substr(0, 2) == "wm " && line[11] == 8'h20) begin
      ok = 1;
      for (int i = 0; i < 8; i++) begin
        ok &= hexval(line[3+i], v);  a = {a[27:0], v};
        ok &= hexval(line[12+i], v); d = {d[27:0], v};
      end
      if (ok) begin wb = 1; t.we = 1; t.adr = a; t.dat = d; end
    end else if (line.len() == 11 && line.substr(0, 2) == "rm ") begin
      ok = 1;
      for (int i = 0; i < 8; i++) begin
        ok &= hexval(line[3+i], v); a = {a[27:0], v};
      end
      if (ok) begin wb = 1; t.we = 0; t.adr = a; end
    end
    if (wb) begin
      if (bus_mode == 1)      resp = "be\n";
      else if (bus_mode == 2) resp = "to\n";
      else if (t.we) begin
        ref_mem[a] = d;
        resp = "ok\n";
      end else begin
        rd = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        resp = {hex8(rd, 1'b1), "\n"};
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, esc(act), esc(exp));
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic run_cmd(input string line, input string term, input bit want_resp);
    string r;
    bit    wb;
    wb_t   t;
    model(line, r, wb, t);
    if (wb) exp_wb.push_back(t);
    if (want_resp) exp_resp.push_back(r);
    send_str({line, term});
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_resp.size() != 0 || busy || tx_req) && n < 1500) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("resp_pending", exp_resp.size(), 0);
    chk("wb_pending", exp_wb.size(), 0);
    chk("idle_busy", busy, 1'b0);
    exp_resp.delete();
    exp_wb.delete();
  endtask

  task automatic wait_cyc();
    int n = 0;
    while (!wbm_cyc_o && n < 500) begin @(negedge clk); n++; end
    chk("wait_cyc", wbm_cyc_o, 1'b1);
  endtask

  task automatic wait_txreq();
    int n = 0;
    while (!tx_req && n < 500) begin @(negedge clk); n++; end
    chk("wait_txreq", tx_req, 1'b1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cyc"}, wbm_cyc_o, 1'b0);
    chk({tag, "_stb"}, wbm_stb_o, 1'b0);
    chk({tag, "_we"}, wbm_we_o, 1'b0);
    chk({tag, "_adr"}, wbm_adr_o, 32'h0);
    chk({tag, "_dat"}, wbm_dat_o, 32'h0);
    chk({tag, "_sel"}, wbm_sel_o, 4'hF);
    chk({tag, "_txreq"}, tx_req, 1'b0);
    chk({tag, "_txdata"}, tx_data, 8'h0);
    chk({tag, "_ovr"}, rx_ovr, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  function automatic string corrupt(input string s);
    string r = "";
    int p = $urandom_range(0, s.len() - 1);
    case ($urandom_range(0, 2))
      0: for (int i = 0; i < p + 1 && i < s.len() - 1; i++) r = $sformatf("%s%c", r, s[i]);
      1: for (int i = 0; i < s.len(); i++)
           r = $sformatf("%s%c", r, (i == p) ? 8'($urandom_range(32, 126)) : s[i]);
      default: r = $sformatf("%s%c", s, 8'($urandom_range(32, 126)));
    endcase
    if (r.len() == 0) r = "x";
    return r;
  endfunction

  // UART transmit side: acks bytes after a random delay and checks each
  // completed reply line against the scoreboard.
  initial begin
    string cur = "";
    logic [7:0] b;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        cur = "";
        tx_ack = 1'b0;
      end else if (tx_ack) begin
        tx_ack = 1'b0;
      end else if (tx_req && $urandom_range(0, 2) == 0) begin
        b = tx_data;
        tx_ack = 1'b1;
        cur = $sformatf("%s%c", cur, b);
        if (b == 8'h0a) begin
          if (exp_resp.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected: got \"%s\" expected no reply", esc(cur));
          end else begin
            chk_str("tx_resp", cur, exp_resp.pop_front());
          end
          cur = "";
        end
      end
    end
  end

  // Wishbone slave: checks each new cycle against the expected transaction,
  // then acks / errors / stays silent according to bus_mode.
  initial begin
    bit in_cyc = 0;
    int cyc_len = 0;
    int ack_at = 1;
    wb_t t;
    forever begin
      @(posedge clk); #1;
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      if (!reset_n) begin
        in_cyc = 0;
      end else if (wbm_cyc_o) begin
        if (!in_cyc) begin
          in_cyc = 1; cyc_len = 0; ack_at = $urandom_range(1, 4);
          if (exp_wb.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_unexpected: got adr %h expected no cycle", wbm_adr_o);
          end else begin
            t = exp_wb.pop_front();
            chk("wb_stb", wbm_stb_o, 1'b1);
            chk("wb_we", wbm_we_o, t.we);
            chk("wb_adr", wbm_adr_o, t.adr);
            chk("wb_sel", wbm_sel_o, 4'hF);
            if (t.we) chk("wb_dat", wbm_dat_o, t.dat);
          end
        end
        cyc_len++;
        if (cyc_len == ack_at && bus_mode == 0) begin
          wbm_ack_i = 1'b1;
          if (wbm_we_o) slv_mem[wbm_adr_o] = wbm_dat_o;
          else wbm_dat_i = slv_mem.exists(wbm_adr_o) ? slv_mem[wbm_adr_o] : dflt(wbm_adr_o);
        end else if (cyc_len == ack_at && bus_mode == 1) begin
          wbm_err_i = 1'b1;
        end
      end else if (in_cyc) begin
        in_cyc = 0;
        if (bus_mode == 2) chk("tmo_len", cyc_len, TMO);
      end
    end
  end

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [31:0] pool[4];
    string line, term;
    int kind, r;
    s_cr   = $sformatf("%c", 8'h0d);
    s_lf   = $sformatf("%c", 8'h0a);
    s_crlf = {s_cr, s_lf};
    pool[0] = 32'h3008_0000; pool[1] = 32'h0000_0010;
    pool[2] = 32'h0000_ABCD; pool[3] = $urandom;

    repeat (3) @(negedge clk);
    chk_reset("rst0");
    reset_n = 1'b1;
    @(negedge clk);

    run_cmd("wm 30080000 11223344", s_lf, 1); wait_idle();
    run_cmd("rm 30080000", s_crlf, 1);         wait_idle();
    run_cmd("rm 3008000G", s_lf, 1);           wait_idle();
    run_cmd("rm 1234", s_lf, 1);               wait_idle();

    bus_mode = 2; run_cmd("rm 30080000", s_lf, 1);          wait_idle();
    bus_mode = 1; run_cmd("wm 30080004 DEADBEEF", s_lf, 1); wait_idle();
    bus_mode = 0;

    run_cmd("rm 30080000", s_crlf, 1);
    wait_txreq();
    send_byte(8'h7a);
    send_byte(8'h71);
    wait_idle();
    chk("rx_ovr_set", rx_ovr, 1'b1);
    run_cmd("wm 0000ABCD 0badf00d", s_lf, 1); wait_idle();
    run_cmd("rm 0000abcd", s_cr, 1);          wait_idle();
    @(negedge clk) cfg_en = 1'b0;
    @(negedge clk);
    chk("rx_ovr_clr", rx_ovr, 1'b0);
    cfg_en = 1'b1;

    send_str("wm 1234");
    @(negedge clk) cfg_en = 1'b0;
    @(negedge clk);
    chk("cfg_off_idle", busy, 1'b0);
    cfg_en = 1'b1;

    bus_mode = 2;
    run_cmd("rm 00000010", s_lf, 0);
    wait_cyc();
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset("rst_wb");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_mode = 0;
    exp_wb.delete();

    run_cmd("rm 30080000", s_lf, 0);
    wait_txreq();
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset("rst_tx");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_wb.delete();

    run_cmd("wm 00000000 CAFEF00D", s_lf, 1); wait_idle();
    run_cmd("rm 00000000", s_lf, 1);          wait_idle();

    for (int k = 0; k < 40; k++) begin
      pool[3] = $urandom;
      kind = $urandom_range(0, 9);
      if (kind < 4)
        line = {"wm ", hex8(pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1))), " ",
                hex8($urandom, 1'($urandom_range(0, 1)))};
      else
        line = {"rm ", hex8(pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)))};
      if (kind >= 7) line = corrupt(line);
      r = $urandom_range(0, 2);
      term = (r == 0) ? s_lf : (r == 1) ? s_cr : s_crlf;
      r = $urandom_range(0, 9);
      bus_mode = (r < 7) ? 0 : (r < 9) ? 1 : 2;
      run_cmd(line, term, 1);
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
